// File: rtl/snake_draw_fsm_if.sv
// Interface bundling the move-request inputs and VGA/status outputs of
// snake_draw_fsm.
//   tick, dir            : move request and requested heading (into the FSM)
//   VGA_x, VGA_y         : pixel coordinate to the VGA adapter
//   VGA_color, plot      : pixel colour and write strobe
//   busy, done           : sequencing status
//   head_x, head_y       : current head cell
// master drives requests (controller / bench); slave is the FSM.
interface snake_draw_fsm_if;
    logic       tick;
    logic [1:0] dir;
    logic [7:0] VGA_x;
    logic [6:0] VGA_y;
    logic [2:0] VGA_color;
    logic       plot;
    logic       busy;
    logic       done;
    logic [5:0] head_x;
    logic [4:0] head_y;

    modport master (
        output tick, dir,
        input  VGA_x, VGA_y, VGA_color, plot, busy, done, head_x, head_y
    );

    modport slave (
        input  tick, dir,
        output VGA_x, VGA_y, VGA_color, plot, busy, done, head_x, head_y
    );
endinterface

// File: rtl/snake_draw_fsm.sv
// Snake movement and drawing sequencer for a VGA framebuffer adapter.
// The body is kept as a circular buffer of cells. After reset the whole body
// is drawn; each accepted tick erases the tail cell, then draws the new head
// cell, one pixel per cycle.
// Ports:
//   CLOCK_50 : clock, all logic on rising edge
//   reset    : synchronous active-high reset
//   bus      : snake_draw_fsm_if.slave (tick/dir in; VGA_x/VGA_y/VGA_color,
//              plot, busy, done, head_x/head_y out; all outputs registered)
module snake_draw_fsm #(
    parameter int         BLOCK       = 4,
    parameter int         GRID_W      = 40,
    parameter int         GRID_H      = 30,
    parameter int         LEN         = 4,
    parameter logic [2:0] SNAKE_COLOR = 3'b010,
    parameter logic [2:0] BG_COLOR    = 3'b000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    snake_draw_fsm_if.slave  bus
);

    localparam int BLK_SH = $clog2(BLOCK);
    localparam int PIX_W  = 2 * BLK_SH;
    localparam int IDX_W  = $clog2(LEN);
    localparam int SUM_W  = IDX_W + 1;

    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(BLOCK * BLOCK - 1);
    localparam logic [IDX_W-1:0] CELL_LAST = IDX_W'(LEN - 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ERASE = 3'd2,
        ST_DRAW  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Buffer index a+b modulo LEN (LEN need not be a power of two).
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= SUM_W'(LEN)) begin
            s = s - SUM_W'(LEN);
        end else begin
            s = s;
        end
        return s[IDX_W-1:0];
    endfunction

    // Neighbouring cell in heading h, wrapping at the grid edges. Returns {x, y}.
    function automatic logic [10:0] step_cell(input logic [5:0] x,
                                              input logic [4:0] y,
                                              input logic [1:0] h);
        logic [5:0] nx;
        logic [4:0] ny;
        nx = x;
        ny = y;
        case (h)
            DIR_UP:    ny = (y == 5'd0) ? 5'(GRID_H - 1) : y - 5'd1;
            DIR_RIGHT: nx = (x == 6'(GRID_W - 1)) ? 6'd0 : x + 6'd1;
            DIR_DOWN:  ny = (y == 5'(GRID_H - 1)) ? 5'd0 : y + 5'd1;
            default:   nx = (x == 6'd0) ? 6'(GRID_W - 1) : x - 6'd1;
        endcase
        return {nx, ny};
    endfunction

    state_t           state_r,     state_s;
    logic [PIX_W-1:0] pix_cnt_r,   pix_cnt_s;
    logic [IDX_W-1:0] cell_cnt_r,  cell_cnt_s;
    logic [IDX_W-1:0] tail_ptr_r,  tail_ptr_s;
    logic [1:0]       heading_r,   heading_s;
    logic [5:0]       head_x_r,    head_x_s;
    logic [4:0]       head_y_r,    head_y_s;
    logic [7:0]       vga_x_r,     vga_x_s;
    logic [6:0]       vga_y_r,     vga_y_s;
    logic [2:0]       vga_color_r, vga_color_s;
    logic             plot_r,      plot_s;
    logic             done_r,      done_s;
    logic             busy_r,      busy_s;

    logic [5:0]       body_x_r [LEN];
    logic [4:0]       body_y_r [LEN];
    logic             buf_we_s;

    logic [IDX_W-1:0] rd_idx_s;
    logic [5:0]       cx_s;
    logic [4:0]       cy_s;
    logic [7:0]       pix_x_s;
    logic [6:0]       pix_y_s;
    logic [1:0]       hdg_req_s;
    logic [10:0]      nxt_cell_s;
    logic             pix_last_s;

    // Next-state, datapath and output decode.
    always_comb begin
        state_s     = state_r;
        pix_cnt_s   = pix_cnt_r;
        cell_cnt_s  = cell_cnt_r;
        tail_ptr_s  = tail_ptr_r;
        heading_s   = heading_r;
        head_x_s    = head_x_r;
        head_y_s    = head_y_r;
        vga_x_s     = vga_x_r;
        vga_y_s     = vga_y_r;
        vga_color_s = vga_color_r;
        plot_s      = 1'b0;
        done_s      = 1'b0;
        buf_we_s    = 1'b0;

        // cell_cnt is only non-zero during INIT, so in ERASE this is the tail.
        rd_idx_s = wrap_add(tail_ptr_r, cell_cnt_r);
        if (state_r == ST_DRAW) begin
            cx_s = head_x_r;
            cy_s = head_y_r;
        end else begin
            cx_s = body_x_r[rd_idx_s];
            cy_s = body_y_r[rd_idx_s];
        end
        pix_x_s    = (8'(cx_s) << BLK_SH) + 8'(pix_cnt_r[BLK_SH-1:0]);
        pix_y_s    = (7'(cy_s) << BLK_SH) + 7'(pix_cnt_r[PIX_W-1:BLK_SH]);
        pix_last_s = (pix_cnt_r == PIX_LAST);

        // A reversal request would fold the snake onto itself; keep heading.
        if (bus.dir == (heading_r ^ 2'b10)) begin
            hdg_req_s = heading_r;
        end else begin
            hdg_req_s = bus.dir;
        end
        nxt_cell_s = step_cell(head_x_r, head_y_r, hdg_req_s);

        case (state_r)
            ST_INIT: begin
                plot_s      = 1'b1;
                vga_x_s     = pix_x_s;
                vga_y_s     = pix_y_s;
                vga_color_s = SNAKE_COLOR;
                if (pix_last_s) begin
                    pix_cnt_s = PIX_W'(0);
                    if (cell_cnt_r == CELL_LAST) begin
                        cell_cnt_s = IDX_W'(0);
                        state_s    = ST_DONE;
                    end else begin
                        cell_cnt_s = cell_cnt_r + IDX_W'(1);
                    end
                end else begin
                    pix_cnt_s = pix_cnt_r + PIX_W'(1);
                end
            end
            ST_IDLE: begin
                if (bus.tick) begin
                    heading_s              = hdg_req_s;
                    {head_x_s, head_y_s}   = nxt_cell_s;
                    state_s                = ST_ERASE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ERASE: begin
                plot_s      = 1'b1;
                vga_x_s     = pix_x_s;
                vga_y_s     = pix_y_s;
                vga_color_s = BG_COLOR;
                if (pix_last_s) begin
                    // Head overwrites the tail slot; the next entry becomes tail.
                    pix_cnt_s  = PIX_W'(0);
                    buf_we_s   = 1'b1;
                    tail_ptr_s = wrap_add(tail_ptr_r, IDX_W'(1));
                    state_s    = ST_DRAW;
                end else begin
                    pix_cnt_s = pix_cnt_r + PIX_W'(1);
                end
            end
            ST_DRAW: begin
                plot_s      = 1'b1;
                vga_x_s     = pix_x_s;
                vga_y_s     = pix_y_s;
                vga_color_s = SNAKE_COLOR;
                if (pix_last_s) begin
                    pix_cnt_s = PIX_W'(0);
                    state_s   = ST_DONE;
                end else begin
                    pix_cnt_s = pix_cnt_r + PIX_W'(1);
                end
            end
            ST_DONE: begin
                done_s  = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                pix_cnt_s  = PIX_W'(0);
                cell_cnt_s = IDX_W'(0);
                state_s    = ST_INIT;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State, body buffer and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r     <= ST_INIT;
            pix_cnt_r   <= PIX_W'(0);
            cell_cnt_r  <= IDX_W'(0);
            tail_ptr_r  <= IDX_W'(0);
            heading_r   <= DIR_RIGHT;
            head_x_r    <= 6'(GRID_W / 2);
            head_y_r    <= 5'(GRID_H / 2);
            vga_x_r     <= 8'd0;
            vga_y_r     <= 7'd0;
            vga_color_r <= 3'd0;
            plot_r      <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b1;
            for (int i = 0; i < LEN; i++) begin
                body_x_r[i] <= 6'(GRID_W / 2 - LEN + 1 + i);
                body_y_r[i] <= 5'(GRID_H / 2);
            end
        end else begin
            state_r     <= state_s;
            pix_cnt_r   <= pix_cnt_s;
            cell_cnt_r  <= cell_cnt_s;
            tail_ptr_r  <= tail_ptr_s;
            heading_r   <= heading_s;
            head_x_r    <= head_x_s;
            head_y_r    <= head_y_s;
            vga_x_r     <= vga_x_s;
            vga_y_r     <= vga_y_s;
            vga_color_r <= vga_color_s;
            plot_r      <= plot_s;
            done_r      <= done_s;
            busy_r      <= busy_s;
            if (buf_we_s) begin
                body_x_r[tail_ptr_r] <= head_x_r;
                body_y_r[tail_ptr_r] <= head_y_r;
            end
        end
    end

    assign bus.VGA_x     = vga_x_r;
    assign bus.VGA_y     = vga_y_r;
    assign bus.VGA_color = vga_color_r;
    assign bus.plot      = plot_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.head_x    = head_x_r;
    assign bus.head_y    = head_y_r;

endmodule

// File: tb/tb_snake_draw_fsm.sv
// Directed self-checking bench for snake_draw_fsm with default parameters.
module tb_snake_draw_fsm;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int x;
        int y;
    } cell_t;

    cell_t body_q[$];

    snake_draw_fsm_if bus();

    snake_draw_fsm dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cell: 16 plot cycles, row-major within the 4x4 block.
    task automatic expect_cell(input int cx, input int cy, input int col, input string tag);
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("%s.plot[%0d]", tag, k), bus.plot, 1);
            chk($sformatf("%s.x[%0d]", tag, k), bus.VGA_x, cx * 4 + (k % 4));
            chk($sformatf("%s.y[%0d]", tag, k), bus.VGA_y, cy * 4 + (k / 4));
            chk($sformatf("%s.col[%0d]", tag, k), bus.VGA_color, col);
        end
    endtask

    task automatic reset_body();
        body_q.delete();
        for (int i = 0; i < 4; i++) body_q.push_back('{17 + i, 15});
    endtask

    // Full post-reset draw of the 4-cell body, then the done pulse.
    task automatic expect_init(input string tag);
        for (int i = 0; i < 4; i++) begin
            expect_cell(17 + i, 15, 2, $sformatf("%s.cell%0d", tag, i));
        end
        step();
        chk({tag, ".done"}, bus.done, 1);
        chk({tag, ".done_plot"}, bus.plot, 0);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".hold_x"}, bus.VGA_x, 83);
        chk({tag, ".hold_y"}, bus.VGA_y, 63);
        chk({tag, ".head_x"}, bus.head_x, 20);
        chk({tag, ".head_y"}, bus.head_y, 15);
        step();
        chk({tag, ".done_low"}, bus.done, 0);
        chk({tag, ".idle_plot"}, bus.plot, 0);
    endtask

    // One accepted move: erase old tail, draw new head (ex,ey), done at cycle 33.
    task automatic do_move(input logic [1:0] d, input int ex, input int ey, input string tag);
        cell_t t;
        t = body_q.pop_front();
        body_q.push_back('{ex, ey});
        bus.tick = 1'b1;
        bus.dir  = d;
        step();
        bus.tick = 1'b0;
        bus.dir  = d ^ 2'b10;
        chk({tag, ".head_x"}, bus.head_x, ex);
        chk({tag, ".head_y"}, bus.head_y, ey);
        chk({tag, ".busy"}, bus.busy, 1);
        chk({tag, ".plot0"}, bus.plot, 0);
        expect_cell(t.x, t.y, 0, {tag, ".erase"});
        expect_cell(ex, ey, 2, {tag, ".draw"});
        step();
        chk({tag, ".done"}, bus.done, 1);
        chk({tag, ".done_plot"}, bus.plot, 0);
        chk({tag, ".hold_x"}, bus.VGA_x, ex * 4 + 3);
        chk({tag, ".hold_y"}, bus.VGA_y, ey * 4 + 3);
        step();
        chk({tag, ".done_low"}, bus.done, 0);
        chk({tag, ".idle"}, bus.busy, 0);
    endtask

    initial begin
        int plots;
        int dones;

        reset    = 1'b1;
        bus.tick = 1'b0;
        bus.dir  = 2'b00;
        step();
        step();
        chk("rst.plot", bus.plot, 0);
        chk("rst.done", bus.done, 0);
        chk("rst.x", bus.VGA_x, 0);
        chk("rst.y", bus.VGA_y, 0);
        chk("rst.col", bus.VGA_color, 0);
        chk("rst.busy", bus.busy, 1);
        chk("rst.head_x", bus.head_x, 20);
        chk("rst.head_y", bus.head_y, 15);

        // Reset release: body drawn tail first, (68,60) .. (83,63).
        reset = 1'b0;
        reset_body();
        expect_init("init");

        // Basic moves and reversal rejection.
        do_move(2'b01, 21, 15, "right");
        do_move(2'b11, 22, 15, "rev_left");
        do_move(2'b00, 22, 14, "up");

        // Run right to the east edge and wrap to column 0.
        for (int x = 23; x <= 39; x++) do_move(2'b01, x, 14, "east");
        do_move(2'b01, 0, 14, "wrap_x");

        // Run up to the top edge and wrap to row 29.
        for (int y = 13; y >= 0; y--) do_move(2'b00, 0, y, "north");
        do_move(2'b00, 0, 29, "wrap_y");
        do_move(2'b10, 0, 28, "rev_down");

        // Tick pulsed mid-draw is dropped: one done, one cell of travel.
        bus.tick = 1'b1;
        bus.dir  = 2'b00;
        step();
        plots = 0;
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 9) begin
                bus.tick = 1'b1;
                bus.dir  = 2'b01;
            end else begin
                bus.tick = 1'b0;
            end
            step();
            if (bus.plot === 1'b1) plots++;
            if (bus.done === 1'b1) dones++;
        end
        bus.tick = 1'b0;
        chk("busy_tick.plots", plots, 32);
        chk("busy_tick.dones", dones, 1);
        chk("busy_tick.head_x", bus.head_x, 0);
        chk("busy_tick.head_y", bus.head_y, 27);
        chk("busy_tick.busy", bus.busy, 0);

        // Reset during DRAW abandons the move and redraws the reset body.
        bus.tick = 1'b1;
        bus.dir  = 2'b01;
        step();
        bus.tick = 1'b0;
        chk("mid.head_x", bus.head_x, 1);
        chk("mid.head_y", bus.head_y, 27);
        repeat (20) step();
        chk("mid.plot_before", bus.plot, 1);
        reset = 1'b1;
        step();
        chk("mid_rst.plot", bus.plot, 0);
        chk("mid_rst.done", bus.done, 0);
        chk("mid_rst.busy", bus.busy, 1);
        chk("mid_rst.x", bus.VGA_x, 0);
        step();
        chk("mid_rst.plot2", bus.plot, 0);
        chk("mid_rst.head_x", bus.head_x, 20);
        reset = 1'b0;
        reset_body();
        expect_init("reinit");
        do_move(2'b01, 21, 15, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
